// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes,
// FSM state encoding and fault cause encoding.
package lsu_pkg;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_D  = 3'd3;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;
  localparam logic [2:0] LSU_WU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_ILLEGAL  = 2'd2,
    FAULT_TIMEOUT  = 2'd3
  } lsu_fault_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [NB-1:0]     be;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: funct3 legality, alignment check, store lane
// replication with byte enables, and load lane extraction with extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [OW-1:0]   i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [OW-1:0]   i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic            o_legal,
  output logic            o_aligned,
  output logic [XLEN-1:0] o_wdata,
  output logic [NB-1:0]   o_be,
  output logic [XLEN-1:0] o_rdata
);

  logic [2:0]      w_off3;
  logic [XLEN-1:0] w_rep;
  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_shift;

  // Offset widened to 3 bits so the double-word check works for any XLEN
  assign w_off3 = 3'(i_off);

  // Legal size/sign codes differ between loads and stores and with XLEN
  always_comb begin
    o_legal = 1'b0;
    if (i_we) begin
      case (i_funct3)
        LSU_B, LSU_H, LSU_W: o_legal = 1'b1;
        LSU_D:               o_legal = (XLEN == 64);
        default:             o_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: o_legal = 1'b1;
        LSU_D, LSU_WU:                      o_legal = (XLEN == 64);
        default:                            o_legal = 1'b0;
      endcase
    end
  end

  // Natural alignment: the low log2(size) address bits must be zero
  always_comb begin
    o_aligned = 1'b1;
    case (i_funct3[1:0])
      2'd0:    o_aligned = 1'b1;
      2'd1:    o_aligned = (w_off3[0] == 1'b0);
      2'd2:    o_aligned = (w_off3[1:0] == 2'b00);
      default: o_aligned = (w_off3 == 3'b000);
    endcase
  end

  // Replicate the right-aligned store datum across all lanes; the byte
  // enables then pick the lane(s) that actually get written
  always_comb begin
    w_rep  = i_wdata;
    w_mask = '1;
    case (i_funct3[1:0])
      2'd0: begin
        w_rep  = {NB{i_wdata[7:0]}};
        w_mask = NB'(1);
      end
      2'd1: begin
        w_rep  = {(NB/2){i_wdata[15:0]}};
        w_mask = NB'(3);
      end
      2'd2: begin
        w_rep  = {(NB/4){i_wdata[31:0]}};
        w_mask = NB'(15);
      end
      default: ;
    endcase
  end

  assign o_wdata = w_rep;
  assign o_be    = i_we ? NB'(w_mask << i_off) : '1;

  // Loads read the whole word; shift the addressed lane down to bit 0
  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  // Truncate to the access size, then sign- or zero-extend
  always_comb begin
    o_rdata = w_shift;
    case (i_ld_funct3)
      LSU_B:   o_rdata = XLEN'($signed(w_shift[7:0]));
      LSU_H:   o_rdata = XLEN'($signed(w_shift[15:0]));
      LSU_W:   o_rdata = XLEN'($signed(w_shift[31:0]));
      LSU_BU:  o_rdata = XLEN'(w_shift[7:0]);
      LSU_HU:  o_rdata = XLEN'(w_shift[15:0]);
      LSU_WU:  o_rdata = XLEN'(w_shift[31:0]);
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time from the pipeline, drives a
// req/ack memory handshake with a timeout, and returns formatted load data
// plus a fault cause with a one-cycle done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int NB      = XLEN / 8,
  localparam int OW      = $clog2(NB)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [2:0]          i_funct3,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [XLEN-1:0]     i_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic [XLEN-1:0]     o_rdata,
  output logic [1:0]          o_fault,
  load_store_unit_if.master   mem
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        r_state;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_rdata;
  lsu_fault_e        r_fault;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [NB-1:0]     r_mem_be;
  logic [OW-1:0]     r_off;
  logic [2:0]        r_f3;
  logic [CW-1:0]     r_cnt;

  logic              w_legal;
  logic              w_aligned;
  logic [XLEN-1:0]   w_wdata;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_ld_data;

  // Store formatting uses the live request; load extraction uses the
  // offset/funct3 latched when the access was accepted
  lsu_align #(.XLEN(XLEN)) u_align (
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_off       (i_addr[OW-1:0]),
    .i_wdata     (i_wdata),
    .i_ld_funct3 (r_f3),
    .i_ld_off    (r_off),
    .i_rdata     (mem.rdata),
    .o_legal     (w_legal),
    .o_aligned   (w_aligned),
    .o_wdata     (w_wdata),
    .o_be        (w_be),
    .o_rdata     (w_ld_data)
  );

  // Access FSM with timeout counter; every output comes straight from a flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_fault     <= FAULT_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_busy <= 1'b1;
            if (!w_legal || !w_aligned) begin
              // Faulting request completes without touching memory
              r_fault <= w_legal ? FAULT_MISALIGN : FAULT_ILLEGAL;
              r_rdata <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_we;
              r_mem_addr  <= {i_addr[ADDR_W-1:OW], {OW{1'b0}}};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
              r_off       <= i_addr[OW-1:0];
              r_f3        <= i_funct3;
              r_cnt       <= '0;
              r_state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem.ack) begin
            // Ack takes priority over a timeout expiring in the same cycle
            r_mem_req <= 1'b0;
            r_rdata   <= r_mem_we ? '0 : w_ld_data;
            r_fault   <= FAULT_NONE;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1)) begin
            r_mem_req <= 1'b0;
            r_rdata   <= '0;
            r_fault   <= FAULT_TIMEOUT;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_fault   = r_fault;
  assign mem.req   = r_mem_req;
  assign mem.we    = r_mem_we;
  assign mem.addr  = r_mem_addr;
  assign mem.wdata = r_mem_wdata;
  assign mem.be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit unit with the default
// timeout, a 32-bit unit with TIMEOUT=4, and a 64-bit unit.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, TIMEOUT=255
  logic        a_req, a_we, a_busy, a_done;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_fault;
  load_store_unit_if #(.XLEN(32), .ADDR_W(32)) a_if ();

  // 32-bit, TIMEOUT=4
  logic        t_req, t_we, t_busy, t_done;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [1:0]  t_fault;
  load_store_unit_if #(.XLEN(32), .ADDR_W(32)) t_if ();

  // 64-bit, TIMEOUT=255
  logic        d_req, d_we, d_busy, d_done;
  logic [2:0]  d_f3;
  logic [31:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic [1:0]  d_fault;
  load_store_unit_if #(.XLEN(64), .ADDR_W(32)) d_if ();

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(255)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(a_req), .i_we(a_we), .i_funct3(a_f3),
    .i_addr(a_addr), .i_wdata(a_wdata), .o_busy(a_busy), .o_done(a_done),
    .o_rdata(a_rdata), .o_fault(a_fault), .mem(a_if)
  );

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_t (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(t_req), .i_we(t_we), .i_funct3(t_f3),
    .i_addr(t_addr), .i_wdata(t_wdata), .o_busy(t_busy), .o_done(t_done),
    .o_rdata(t_rdata), .o_fault(t_fault), .mem(t_if)
  );

  load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(d_req), .i_we(d_we), .i_funct3(d_f3),
    .i_addr(d_addr), .i_wdata(d_wdata), .o_busy(d_busy), .o_done(d_done),
    .o_rdata(d_rdata), .o_fault(d_fault), .mem(d_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept a request on u_a, ack it in the following cycle; returns in DONE
  task automatic a_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mrdata);
    a_req = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wdata;
    tick();
    a_req = 1'b0;
    a_if.ack = 1'b1; a_if.rdata = mrdata;
    tick();
    a_if.ack = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [63:0] mrdata);
    d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
    tick();
    d_req = 1'b0;
    d_if.ack = 1'b1; d_if.rdata = mrdata;
    tick();
    d_if.ack = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_f3 = 0; a_addr = 0; a_wdata = 0; a_if.ack = 0; a_if.rdata = 0;
    t_req = 0; t_we = 0; t_f3 = 0; t_addr = 0; t_wdata = 0; t_if.ack = 0; t_if.rdata = 0;
    d_req = 0; d_we = 0; d_f3 = 0; d_addr = 0; d_wdata = 0; d_if.ack = 0; d_if.rdata = 0;

    // ---- reset state ----
    #12;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_fault", a_fault, 0);
    chk("rst_mem_req", a_if.req, 0);
    chk("rst_mem_be", a_if.be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- SB addr=0x1003: replication, byte enable, ack next cycle ----
    a_req = 1; a_we = 1; a_f3 = 3'd0; a_addr = 32'h1003; a_wdata = 32'h1234_56AB;
    tick();
    a_req = 0;
    chk("sb_mem_req", a_if.req, 1);
    chk("sb_be", a_if.be, 4'b1000);
    chk("sb_wdata", a_if.wdata, 32'hABAB_ABAB);
    chk("sb_addr", a_if.addr, 32'h1000);
    chk("sb_we", a_if.we, 1);
    chk("sb_busy", a_busy, 1);
    chk("sb_done_early", a_done, 0);
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("sb_done", a_done, 1);
    chk("sb_fault", a_fault, 0);
    chk("sb_rdata", a_rdata, 0);
    chk("sb_req_drop", a_if.req, 0);
    tick();
    chk("sb_done_pulse", a_done, 0);
    chk("sb_idle", a_busy, 0);

    // ---- load extraction and extension ----
    a_access(0, 3'd0, 32'h2002, 0, 32'h0080_0000);
    chk("lb_done", a_done, 1);
    chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
    tick();
    a_access(0, 3'd4, 32'h2002, 0, 32'h0080_0000);
    chk("lbu_rdata", a_rdata, 32'h0000_0080);
    tick();
    a_access(0, 3'd1, 32'h2002, 0, 32'h8001_0000);
    chk("lh_rdata", a_rdata, 32'hFFFF_8001);
    tick();
    a_access(0, 3'd5, 32'h2002, 0, 32'h8001_0000);
    chk("lhu_rdata", a_rdata, 32'h0000_8001);
    tick();
    a_access(0, 3'd2, 32'h2004, 0, 32'hCAFE_F00D);
    chk("lw_rdata", a_rdata, 32'hCAFE_F00D);
    tick();

    // ---- SH addr=0x2006: upper half lanes ----
    a_req = 1; a_we = 1; a_f3 = 3'd1; a_addr = 32'h2006; a_wdata = 32'h0000_BEEF;
    tick();
    a_req = 0;
    chk("sh_be", a_if.be, 4'b1100);
    chk("sh_wdata", a_if.wdata, 32'hBEEF_BEEF);
    chk("sh_addr", a_if.addr, 32'h2004);
    a_if.ack = 1;
    tick();
    a_if.ack = 0;
    chk("sh_done", a_done, 1);
    tick();

    // ---- faults: misaligned half, illegal store/load sizes ----
    a_req = 1; a_we = 0; a_f3 = 3'd1; a_addr = 32'h2001;
    tick();
    a_req = 0;
    chk("mis_done", a_done, 1);
    chk("mis_fault", a_fault, 1);
    chk("mis_mem_req", a_if.req, 0);
    chk("mis_rdata", a_rdata, 0);
    chk("mis_busy", a_busy, 1);
    tick();
    chk("mis_done_pulse", a_done, 0);
    chk("mis_idle", a_busy, 0);
    a_req = 1; a_we = 1; a_f3 = 3'd3; a_addr = 32'h0;
    tick();
    a_req = 0;
    chk("sd32_done", a_done, 1);
    chk("sd32_fault", a_fault, 2);
    chk("sd32_mem_req", a_if.req, 0);
    tick();
    a_req = 1; a_we = 0; a_f3 = 3'd6; a_addr = 32'h0;
    tick();
    a_req = 0;
    chk("lwu32_fault", a_fault, 2);
    tick();
    a_req = 1; a_we = 0; a_f3 = 3'd2; a_addr = 32'h2002;
    tick();
    a_req = 0;
    chk("lw_mis_fault", a_fault, 1);
    tick();

    // ---- slow ack with toggling i_req: outputs stable, request ignored ----
    a_req = 1; a_we = 1; a_f3 = 3'd2; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
    tick();
    for (int i = 1; i <= 10; i++) begin
      a_req = (i % 2 == 0); a_we = 0; a_addr = 32'h20; a_wdata = 32'h0;
      chk("slow_req", a_if.req, 1);
      chk("slow_addr", a_if.addr, 32'h10);
      chk("slow_wdata", a_if.wdata, 32'hDEAD_BEEF);
      chk("slow_be", a_if.be, 4'hF);
      chk("slow_we", a_if.we, 1);
      chk("slow_done", a_done, 0);
      if (i == 10) a_if.ack = 1;
      tick();
    end
    a_if.ack = 0;
    a_req = 1; a_we = 0; a_f3 = 3'd2; a_addr = 32'h20;
    chk("slow_done_pulse", a_done, 1);
    tick();
    chk("req_in_done_ignored", a_if.req, 0);
    chk("idle_after_done", a_busy, 0);
    tick();
    a_req = 0;
    chk("b2b_req", a_if.req, 1);
    chk("b2b_addr", a_if.addr, 32'h20);
    chk("b2b_we", a_if.we, 0);
    a_if.ack = 1; a_if.rdata = 32'h0000_0055;
    tick();
    a_if.ack = 0;
    chk("b2b_rdata", a_rdata, 32'h55);
    tick();

    // ---- timeout: no ack ----
    t_req = 1; t_we = 0; t_f3 = 3'd2; t_addr = 32'h0;
    tick();
    t_req = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_req_held", t_if.req, 1);
      chk("to_no_done", t_done, 0);
      tick();
    end
    chk("to_done", t_done, 1);
    chk("to_fault", t_fault, 3);
    chk("to_req_drop", t_if.req, 0);
    chk("to_rdata", t_rdata, 0);
    tick();

    // ---- timeout: ack lands in the last allowed cycle ----
    t_req = 1; t_we = 0; t_f3 = 3'd2; t_addr = 32'h40;
    tick();
    t_req = 0;
    tick();
    tick();
    tick();
    chk("to4_req", t_if.req, 1);
    t_if.ack = 1; t_if.rdata = 32'h1234_5678;
    tick();
    t_if.ack = 0;
    chk("to4_done", t_done, 1);
    chk("to4_fault", t_fault, 0);
    chk("to4_rdata", t_rdata, 32'h1234_5678);
    tick();

    // ---- 64-bit unit ----
    d_req = 1; d_we = 0; d_f3 = 3'd6; d_addr = 32'h4;
    tick();
    d_req = 0;
    chk("lwu64_addr", d_if.addr, 32'h0);
    chk("lwu64_be", d_if.be, 8'hFF);
    d_if.ack = 1; d_if.rdata = 64'h8000_0001_0BAD_F00D;
    tick();
    d_if.ack = 0;
    chk("lwu64_rdata", d_rdata, 64'h0000_0000_8000_0001);
    tick();
    d_access(0, 3'd2, 32'h4, 0, 64'h8000_0001_0BAD_F00D);
    chk("lw64_rdata", d_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();
    d_access(0, 3'd3, 32'h8, 0, 64'h8877_6655_4433_2211);
    chk("ld64_rdata", d_rdata, 64'h8877_6655_4433_2211);
    chk("ld64_fault", d_fault, 0);
    tick();
    d_req = 1; d_we = 1; d_f3 = 3'd2; d_addr = 32'h4; d_wdata = 64'h0000_0000_1122_3344;
    tick();
    d_req = 0;
    chk("sw64_be", d_if.be, 8'hF0);
    chk("sw64_wdata", d_if.wdata, 64'h1122_3344_1122_3344);
    d_if.ack = 1;
    tick();
    d_if.ack = 0;
    chk("sw64_done", d_done, 1);
    tick();
    d_req = 1; d_we = 0; d_f3 = 3'd3; d_addr = 32'h4;
    tick();
    d_req = 0;
    chk("ld64_mis_fault", d_fault, 1);
    tick();

    // ---- asynchronous reset in the middle of WAIT ----
    d_req = 1; d_we = 1; d_f3 = 3'd3; d_addr = 32'h8; d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    d_req = 0;
    chk("arst_pre_req", d_if.req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", d_if.req, 0);
    chk("arst_busy", d_busy, 0);
    chk("arst_done", d_done, 0);
    chk("arst_addr", d_if.addr, 0);
    chk("arst_wdata", d_if.wdata, 0);
    chk("arst_be", d_if.be, 0);
    tick();
    rst_n = 1'b1;
    d_if.ack = 1;
    tick();
    tick();
    d_if.ack = 0;
    chk("late_ack_done", d_done, 0);
    chk("late_ack_busy", d_busy, 0);
    chk("late_ack_req", d_if.req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
